// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for a single shared ALU: tags each issued
// op with {port, seq}, routes tagged results into per-port response FIFOs.
module alu_arbiter #(
  parameter int RSP_DEPTH = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [2:0] req0_sel,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [2:0] req1_sel,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic [7:0] rsp0_data,
  output logic       rsp0_err,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [7:0] rsp1_data,
  output logic       rsp1_err,
  output logic       alu_en,
  output logic [2:0] alu_addr,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [7:0] alu_out,
  input  logic [2:0] alu_out_addr,
  input  logic       alu_out_en,
  output logic       tag_err,
  output logic       timeout
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  logic [2:0]     r_inflight [2];
  logic [1:0]     r_seq      [2];
  logic [1:0]     r_exp      [2];
  logic [8:0]     r_mem      [2][4];
  logic [1:0]     r_wr       [2];
  logic [1:0]     r_rd       [2];
  logic [2:0]     r_count    [2];
  logic           r_ptr;
  logic           r_alu_en;
  logic [2:0]     r_alu_addr;
  logic [7:0]     r_alu_a;
  logic [7:0]     r_alu_b;
  logic [2:0]     r_alu_sel;
  logic           r_tag_err;
  logic           r_timeout;
  logic [WDW-1:0] r_wd;

  logic [1:0] w_valid, w_rdy_in, w_elig, w_grant, w_pop, w_push_ret, w_push_ill;
  logic [2:0] w_sel [2];
  logic [7:0] w_a   [2];
  logic [7:0] w_b   [2];
  logic       w_gid, w_legal, w_rid, w_ret_ok;

  always_comb begin
    w_valid    = {req1_valid, req0_valid};
    w_rdy_in   = {rsp1_ready, rsp0_ready};
    w_sel[0]   = req0_sel;
    w_sel[1]   = req1_sel;
    w_a[0]     = req0_a;
    w_a[1]     = req1_a;
    w_b[0]     = req0_b;
    w_b[1]     = req1_b;
    w_rid      = alu_out_addr[2];
    w_ret_ok   = alu_out_en && (r_inflight[w_rid] != 3'd0) &&
                 (alu_out_addr[1:0] == r_exp[w_rid]);
    w_elig     = '0;
    w_pop      = '0;
    w_push_ret = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      // Illegal ops wait for an empty pipe so their error entry stays in order.
      w_elig[i]     = w_valid[i] &&
                      (({1'b0, r_inflight[i]} + {1'b0, r_count[i]}) < 4'(RSP_DEPTH)) &&
                      ((w_sel[i] != 3'd7) || (r_inflight[i] == 3'd0));
      w_pop[i]      = w_rdy_in[i] && (r_count[i] != 3'd0);
      w_push_ret[i] = w_ret_ok && (w_rid == 1'(i));
    end
    w_grant    = (w_elig == 2'b11) ? (r_ptr ? 2'b10 : 2'b01) : w_elig;
    w_gid      = w_grant[1];
    w_legal    = (w_sel[w_gid] != 3'd7);
    w_push_ill = w_legal ? 2'b00 : w_grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        r_inflight[i] <= '0;
        r_seq[i]      <= '0;
        r_exp[i]      <= '0;
        r_wr[i]       <= '0;
        r_rd[i]       <= '0;
        r_count[i]    <= '0;
        for (int unsigned j = 0; j < 4; j++) r_mem[i][j] <= '0;
      end
      r_ptr      <= 1'b0;
      r_alu_en   <= 1'b0;
      r_alu_addr <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_sel  <= '0;
      r_tag_err  <= 1'b0;
      r_timeout  <= 1'b0;
      r_wd       <= '0;
    end else begin
      r_alu_en <= 1'b0;
      if (|w_grant) begin
        r_ptr <= ~w_gid;
        if (w_legal) begin
          r_alu_en       <= 1'b1;
          r_alu_addr     <= {w_gid, r_seq[w_gid]};
          r_alu_a        <= w_a[w_gid];
          r_alu_b        <= w_b[w_gid];
          r_alu_sel      <= w_sel[w_gid];
          r_seq[w_gid]   <= r_seq[w_gid] + 2'd1;
        end
      end
      for (int unsigned i = 0; i < 2; i++) begin
        r_inflight[i] <= r_inflight[i] + {2'b0, w_grant[i] & w_legal} - {2'b0, w_push_ret[i]};
        if (w_push_ret[i]) r_exp[i] <= r_exp[i] + 2'd1;
        if (w_push_ret[i] || w_push_ill[i]) begin
          r_mem[i][r_wr[i]] <= w_push_ill[i] ? 9'h100 : {1'b0, alu_out};
          r_wr[i]           <= r_wr[i] + 2'd1;
        end
        if (w_pop[i]) r_rd[i] <= r_rd[i] + 2'd1;
        r_count[i] <= r_count[i] + {2'b0, w_push_ret[i] | w_push_ill[i]} - {2'b0, w_pop[i]};
      end
      if (alu_out_en && !w_ret_ok) r_tag_err <= 1'b1;
      // Watchdog saturates one short of TIMEOUT; the next stalled cycle trips it.
      if (alu_out_en || ((r_inflight[0] == 3'd0) && (r_inflight[1] == 3'd0))) begin
        r_wd <= '0;
      end else if (r_wd == WDW'(TIMEOUT - 1)) begin
        r_timeout <= 1'b1;
      end else begin
        r_wd <= r_wd + 1'b1;
      end
    end
  end

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];
  assign rsp0_valid = (r_count[0] != 3'd0);
  assign rsp1_valid = (r_count[1] != 3'd0);
  assign rsp0_data  = r_mem[0][r_rd[0]][7:0];
  assign rsp0_err   = r_mem[0][r_rd[0]][8];
  assign rsp1_data  = r_mem[1][r_rd[1]][7:0];
  assign rsp1_err   = r_mem[1][r_rd[1]][8];
  assign alu_en     = r_alu_en;
  assign alu_addr   = r_alu_addr;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_sel    = r_alu_sel;
  assign tag_err    = r_tag_err;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: queue-based cycle model checked every negedge, plus
// directed scenarios with hand-computed literal expectations.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid, req1_valid, rsp0_ready, rsp1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_sel, req1_sel;
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [7:0] rsp0_data, rsp1_data, alu_a, alu_b, alu_out;
  logic [2:0] alu_addr, alu_sel, alu_out_addr;
  logic       alu_en, alu_out_en, tag_err, timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.RSP_DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .alu_en(alu_en), .alu_addr(alu_addr), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_out_addr(alu_out_addr), .alu_out_en(alu_out_en),
    .tag_err(tag_err), .timeout(timeout)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_infl [2];
  int         m_seq  [2];
  int         m_exp  [2];
  int         m_ptr, m_wd;
  logic       m_te, m_to, m_en;
  logic [2:0] m_addr, m_sel;
  logic [7:0] m_a, m_b;
  logic [8:0] mq0 [$];
  logic [8:0] mq1 [$];

  function automatic void mreset();
    for (int i = 0; i < 2; i++) begin
      m_infl[i] = 0; m_seq[i] = 0; m_exp[i] = 0;
    end
    m_ptr = 0; m_wd = 0; m_te = 0; m_to = 0; m_en = 0;
    m_addr = '0; m_sel = '0; m_a = '0; m_b = '0;
    mq0.delete(); mq1.delete();
  endfunction

  function automatic void mpush(input int p, input logic [8:0] e);
    if (p == 0) mq0.push_back(e);
    else        mq1.push_back(e);
  endfunction

  initial mreset();

  always @(negedge clk) begin : cmp
    int         g, occ, id;
    logic [1:0] el;
    logic       v [2];
    logic [2:0] s [2];
    logic [7:0] a [2];
    logic [7:0] b [2];
    if (!rst_n) mreset();
    v[0] = req0_valid; v[1] = req1_valid;
    s[0] = req0_sel;   s[1] = req1_sel;
    a[0] = req0_a;     a[1] = req1_a;
    b[0] = req0_b;     b[1] = req1_b;
    for (int i = 0; i < 2; i++) begin
      occ   = m_infl[i] + ((i == 0) ? mq0.size() : mq1.size());
      el[i] = v[i] && (occ < 4) && ((s[i] != 3'd7) || (m_infl[i] == 0));
    end
    if (el == 2'b11) g = m_ptr;
    else if (el[0])  g = 0;
    else if (el[1])  g = 1;
    else             g = -1;

    chk("req0_ready", req0_ready, g == 0);
    chk("req1_ready", req1_ready, g == 1);
    chk("alu_en", alu_en, m_en);
    if (m_en) begin
      chk("alu_addr", alu_addr, m_addr);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_sel", alu_sel, m_sel);
    end
    chk("rsp0_valid", rsp0_valid, mq0.size() > 0);
    if (mq0.size() > 0) begin
      chk("rsp0_data", rsp0_data, mq0[0][7:0]);
      chk("rsp0_err", rsp0_err, mq0[0][8]);
    end
    chk("rsp1_valid", rsp1_valid, mq1.size() > 0);
    if (mq1.size() > 0) begin
      chk("rsp1_data", rsp1_data, mq1[0][7:0]);
      chk("rsp1_err", rsp1_err, mq1[0][8]);
    end
    chk("tag_err", tag_err, m_te);
    chk("timeout", timeout, m_to);

    if (rst_n) begin
      if (rsp0_ready && mq0.size() > 0) void'(mq0.pop_front());
      if (rsp1_ready && mq1.size() > 0) void'(mq1.pop_front());
      if (alu_out_en || (m_infl[0] + m_infl[1]) == 0) m_wd = 0;
      else begin
        m_wd++;
        if (m_wd >= 16) m_to = 1;
      end
      if (alu_out_en) begin
        id = int'(alu_out_addr[2]);
        if (m_infl[id] > 0 && int'(alu_out_addr[1:0]) == m_exp[id]) begin
          mpush(id, {1'b0, alu_out});
          m_infl[id]--;
          m_exp[id] = (m_exp[id] + 1) % 4;
        end else m_te = 1;
      end
      m_en = 0;
      if (g >= 0) begin
        m_ptr = 1 - g;
        if (s[g] == 3'd7) mpush(g, 9'h100);
        else begin
          m_en   = 1;
          m_addr = 3'(g * 4 + m_seq[g]);
          m_a    = a[g];
          m_b    = b[g];
          m_sel  = s[g];
          m_seq[g] = (m_seq[g] + 1) % 4;
          m_infl[g]++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic        auto_alu;
  logic        inj_v;
  logic [10:0] inj;
  logic [11:0] pend;
  int          en_pulses;

  // Bench ALU: when auto_alu is set, each issue returns (a^b) two cycles later.
  task automatic step();
    logic [11:0] cap;
    cap = (auto_alu && alu_en) ? {1'b1, alu_addr, alu_a ^ alu_b} : 12'h000;
    if (alu_en) en_pulses++;
    @(posedge clk);
    #1;
    if (inj_v) begin
      {alu_out_en, alu_out_addr, alu_out} = {1'b1, inj};
      inj_v = 1'b0;
    end else begin
      {alu_out_en, alu_out_addr, alu_out} = pend;
    end
    pend = cap;
  endtask

  task automatic set0(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    req0_valid = v; req0_a = a; req0_b = b; req0_sel = s;
  endtask

  task automatic set1(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    req1_valid = v; req1_a = a; req1_b = b; req1_sel = s;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set0(0, 8'h00, 8'h00, 3'd0);
    set1(0, 8'h00, 8'h00, 3'd0);
    rsp0_ready = 0; rsp1_ready = 0;
    auto_alu = 0; inj_v = 0; pend = '0;
    step(); step();
    rst_n = 1'b1;
    en_pulses = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL sim_timeout: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [2:0] alog [4];
    int nlog, gcnt;
    set0(0, 8'h00, 8'h00, 3'd0);
    set1(0, 8'h00, 8'h00, 3'd0);
    rsp0_ready = 0; rsp1_ready = 0;
    alu_out = '0; alu_out_addr = '0; alu_out_en = 0;
    auto_alu = 0; inj_v = 0; inj = '0; pend = '0; en_pulses = 0;
    do_reset();
    chk("rst_alu_en", alu_en, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_tag_err", tag_err, 0);
    chk("rst_timeout", timeout, 0);

    // single op on port 0
    set0(1, 8'h10, 8'h05, 3'd2);
    #1 chk("t1_req0_ready", req0_ready, 1);
    chk("t1_req1_ready", req1_ready, 0);
    step();
    req0_valid = 0;
    chk("t1_alu_en", alu_en, 1);
    chk("t1_alu_addr", alu_addr, 3'b000);
    chk("t1_alu_a", alu_a, 8'h10);
    chk("t1_alu_b", alu_b, 8'h05);
    chk("t1_alu_sel", alu_sel, 3'd2);
    inj = {3'b000, 8'h00}; inj_v = 1;
    step();
    chk("t1_alu_en_low", alu_en, 0);
    step();
    chk("t1_rsp0_valid", rsp0_valid, 1);
    chk("t1_rsp0_data", rsp0_data, 8'h00);
    chk("t1_rsp0_err", rsp0_err, 0);
    rsp0_ready = 1; step(); rsp0_ready = 0;
    chk("t1_rsp0_drained", rsp0_valid, 0);

    // both ports streaming, alternating grants
    do_reset();
    auto_alu = 1; rsp0_ready = 1; rsp1_ready = 1;
    set0(1, 8'h01, 8'h02, 3'd0);
    set1(1, 8'h03, 8'h04, 3'd1);
    nlog = 0;
    for (int i = 0; i < 14; i++) begin
      if (alu_en && nlog < 4) begin alog[nlog] = alu_addr; nlog++; end
      step();
    end
    req0_valid = 0; req1_valid = 0;
    repeat (5) step();
    chk("t2_nlog", nlog, 4);
    chk("t2_addr0", alog[0], 3'b000);
    chk("t2_addr1", alog[1], 3'b100);
    chk("t2_addr2", alog[2], 3'b001);
    chk("t2_addr3", alog[3], 3'b101);

    // credit limit with blocked response consumer
    do_reset();
    auto_alu = 1;
    set0(1, 8'h07, 8'h09, 3'd3);
    gcnt = 0;
    for (int i = 0; i < 12; i++) begin
      #1 if (req0_ready) gcnt++;
      step();
    end
    chk("t3_grants", gcnt, 4);
    chk("t3_blocked", req0_ready, 0);
    rsp0_ready = 1;
    gcnt = 0;
    for (int i = 0; i < 10; i++) begin
      #1 if (req0_ready) gcnt++;
      step();
      rsp0_ready = 0;
    end
    chk("t3_after_pop", gcnt, 1);
    req0_valid = 0;

    // illegal op waits for in-flight op on port 1
    do_reset();
    set1(1, 8'h30, 8'h2A, 3'd2);
    #1 chk("t4_first_ready", req1_ready, 1);
    step();
    set1(1, 8'h00, 8'h00, 3'd7);
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4_hold", req1_ready, 0);
      step();
    end
    inj = {3'b100, 8'h5A}; inj_v = 1;
    #1 chk("t4_hold_pre", req1_ready, 0);
    step();
    #1 chk("t4_hold_ret", req1_ready, 0);
    step();
    #1 chk("t4_accept", req1_ready, 1);
    step();
    req1_valid = 0;
    chk("t4_no_issue", alu_en, 0);
    chk("t4_rsp1_valid", rsp1_valid, 1);
    chk("t4_rsp1_data", rsp1_data, 8'h5A);
    chk("t4_rsp1_err", rsp1_err, 0);
    rsp1_ready = 1; step(); rsp1_ready = 0;
    chk("t4_rsp1_valid2", rsp1_valid, 1);
    chk("t4_rsp1_data2", rsp1_data, 8'h00);
    chk("t4_rsp1_err2", rsp1_err, 1);
    rsp1_ready = 1; step(); rsp1_ready = 0;
    chk("t4_rsp1_empty", rsp1_valid, 0);
    chk("t4_en_pulses", en_pulses, 1);

    // unexpected tag, then watchdog
    do_reset();
    inj = {3'b010, 8'hAB}; inj_v = 1;
    step();
    chk("t5_tag_err_pre", tag_err, 0);
    step();
    chk("t5_tag_err", tag_err, 1);
    chk("t5_rsp0_none", rsp0_valid, 0);
    set0(1, 8'h01, 8'h01, 3'd0);
    step();
    req0_valid = 0;
    repeat (15) step();
    chk("t5_timeout_pre", timeout, 0);
    step();
    chk("t5_timeout", timeout, 1);

    // reset with work outstanding
    do_reset();
    set0(1, 8'h21, 8'h03, 3'd1);
    step();
    req0_valid = 0;
    inj = {3'b000, 8'h11}; inj_v = 1;
    step();
    step();
    req0_valid = 1;
    step();
    step();
    req0_valid = 0;
    chk("t6_alu_addr", alu_addr, 3'b010);
    chk("t6_rsp0_valid", rsp0_valid, 1);
    chk("t6_rsp0_data", rsp0_data, 8'h11);
    rst_n = 0;
    #1;
    chk("t6_rst_alu_en", alu_en, 0);
    chk("t6_rst_alu_addr", alu_addr, 3'b000);
    chk("t6_rst_alu_a", alu_a, 8'h00);
    chk("t6_rst_alu_sel", alu_sel, 3'd0);
    chk("t6_rst_rsp0_valid", rsp0_valid, 0);
    chk("t6_rst_rsp0_data", rsp0_data, 8'h00);
    chk("t6_rst_req0_ready", req0_ready, 0);
    step();
    rst_n = 1;
    inj = {3'b001, 8'h22}; inj_v = 1;
    step();
    step();
    chk("t6_stale_tag_err", tag_err, 1);
    chk("t6_stale_rsp0", rsp0_valid, 0);
    set0(1, 8'h44, 8'h55, 3'd4);
    #1 chk("t6_new_ready", req0_ready, 1);
    step();
    req0_valid = 0;
    chk("t6_new_alu_en", alu_en, 1);
    chk("t6_new_alu_addr", alu_addr, 3'b000);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one ALU instance between two requesters (port 0, port 1), each with valid/ready command and response channels.
- Issues at most one operation per cycle to the ALU and tags it with a 3-bit addr: {requester id, 2-bit sequence}.
- Routes each tagged ALU result back into a per-requester response FIFO.
- Sits between the ALU and the upstream command sources; owns the ALU's alu_en/addr/a/b/sel inputs.

Parameters:
RSP_DEPTH, 4, entries per response FIFO; also the per-requester in-flight plus buffered credit limit (fixed to 4 by the 2-bit sequence field).
TIMEOUT, 16, consecutive cycles with in-flight ops and no alu_out_en before the watchdog fires.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid / req1_valid  in  1  command valid
req0_ready / req1_ready  out  1  command accepted this cycle (combinational)
req0_a / req1_a  in  8  operand a
req0_b / req1_b  in  8  operand b
req0_sel / req1_sel  in  3  ALU op select, 0..6 legal, 7 illegal
rsp0_valid / rsp1_valid  out  1  response FIFO non-empty
rsp0_ready / rsp1_ready  in  1  response consumed when valid&ready
rsp0_data / rsp1_data  out  8  result at FIFO head
rsp0_err / rsp1_err  out  1  head entry is an illegal-sel error
alu_en  out  1  one-cycle issue strobe to ALU
alu_addr  out  3  tag: bit2 = requester id, bits1:0 = sequence
alu_a, alu_b  out  8  operands
alu_sel  out  3  op select
alu_out  in  8  ALU result
alu_out_addr  in  3  tag returned with result
alu_out_en  in  1  result valid
tag_err  out  1  sticky: unexpected returned tag
timeout  out  1  sticky: watchdog fired

Behaviour:
- Reset (async, rst_n low): all outputs 0; FIFOs empty; in-flight counters 0; sequence counters 0; round-robin pointer = port 0; sticky flags 0. Reset mid-operation discards in-flight ops; later alu_out_en returns raise tag_err (in-flight 0).
- Eligibility of port i: reqi_valid, AND inflight_i + fifo_count_i < RSP_DEPTH, AND (sel != 7 OR inflight_i == 0).
- Arbitration: round robin. If both ports are eligible, grant the port the pointer names; pointer moves to the other port after each grant. A single eligible port is granted regardless of the pointer. reqi_ready = granted this cycle. At most one grant per cycle.
- Legal grant (sel 0..6): next cycle alu_en=1 with alu_a/alu_b/alu_sel = the captured operands and alu_addr = {i, seq_i}. Then seq_i++ (wraps 3->0) and inflight_i++. alu_en is low on every other cycle; the other alu_* outputs hold their last values.
- Illegal grant (sel 7): no ALU issue; push {data=0, err=1} into FIFO i next cycle. The inflight_i==0 rule preserves response order.
- Return: on alu_out_en, id = alu_out_addr[2]. If inflight_id > 0 and alu_out_addr[1:0] == expected return sequence for id, push {alu_out, err=0} into FIFO id, decrement inflight_id, and increment the expected sequence. Otherwise set tag_err and drop the result. Counters are unchanged on a drop.
- Counters: a grant and a return in the same cycle for the same port net to zero change. A push and a pop in the same cycle on the same FIFO leave the count unchanged. Credit guarantees a FIFO never overflows. Popping an empty FIFO is a no-op.
- Response outputs: rspi_valid = FIFO i non-empty; rspi_data/rspi_err show the head entry, registered.
- Watchdog: counter clears on any alu_out_en or when total in-flight is 0; otherwise it increments. At TIMEOUT, set timeout (sticky until reset). Arbitration continues.

Test Plan:
- Port 0 only, a=8'h10, b=8'h05, sel=2: req0_ready same cycle; alu_en next cycle with alu_addr=3'b000; return alu_out=8'h00 tag 000 -> rsp0_valid, rsp0_data=8'h00, rsp0_err=0.
- Both ports valid every cycle, all rsp_ready=1, ALU returning 2 cycles after issue: grants alternate 0,1,0,1; alu_addr sequence 000,100,001,101; each response reaches the correct port in order.
- rsp0_ready=0, port 0 streaming: exactly 4 grants, then req0_ready stays 0. After one pop, exactly one further grant.
- Port 1 sel=7 while inflight_1=1: req1_ready=0 until the return arrives. Then accepted -> rsp1 entries are result then {0, err=1}; alu_en never pulses for the sel=7 command.
- alu_out_en with alu_out_addr=3'b010 while inflight_0=0 -> tag_err=1, no FIFO change. Separately, one issue with no return for 16 cycles -> timeout=1.
- Assert rst_n low with 2 ops in flight and 1 FIFO entry: all outputs 0 immediately. After release, a stale return raises tag_err; a new grant uses sequence 0.
